membrane_element: RTL and testbench
===================================

# membrane_element

Integrate-and-fire membrane stage that sits directly upstream of `activation_element`. It accumulates signed partial sums streamed from a systolic-array column over one timestep, adds them to a persistent membrane potential, and presents the result for one cycle to the threshold/accumulator pair. It then samples the returned spike and updates the stored potential: soft reset on a spike, leak otherwise. One `start` runs a frame of `NUM_TIMESTEPS` timesteps.

## Interface
- `DATA_WIDTH`, 16: width of partial sums, threshold and membrane potential (two's complement).
- `NUM_TIMESTEPS`, 8: timesteps per frame, ≥1.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  frame start pulse; honoured only in IDLE.
- `in_valid`  in  1  partial-sum beat valid.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `in_last`  in  1  qualifies the final beat of the current timestep.
- `partial_sum`  in  DATA_WIDTH  signed input current.
- `threshold`  in  DATA_WIDTH  signed; same value driven to `activation_element`.
- `leak_shift`  in  4  leak = potential >>> leak_shift; 0 disables leak.
- `spike`  in  1  combinational spike returned by `activation_element`.
- `membrane_potential`  out  DATA_WIDTH  registered; drives `activation_element`.
- `mp_valid`  out  1  high exactly in the FIRE cycle.
- `timestep`  out  clog2(NUM_TIMESTEPS) (min 1)  index of the current timestep.
- `done`  out  1  one-cycle pulse after the final FIRE.

## Operation
- States:
  - IDLE: `in_ready`=0. `start` clears `vmem`, `acc` and `timestep`, then goes to ACCUM.
  - ACCUM: `in_ready`=1.
    - Each accepted beat: `acc` <= sat(`acc` + `partial_sum`).
    - Accepted beat with `in_last`: `membrane_potential` <= sat(`vmem` + sat(`acc` + `partial_sum`)), then go to FIRE.
  - FIRE: `mp_valid`=1 and `spike` is sampled. At the clock edge:
    - Spike: `vmem` <= sat(`membrane_potential` − `threshold`).
    - No spike, `leak_shift`≠0: `vmem` <= `membrane_potential` − (`membrane_potential` >>> `leak_shift`).
    - No spike, `leak_shift`=0: `vmem` <= `membrane_potential`.
    - `acc` <= 0.
    - If `timestep` = NUM_TIMESTEPS−1: go to IDLE and assert `done` for the next cycle. Otherwise `timestep`++ and go to ACCUM.
- Saturation clamps to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]. No wrap-around is permitted anywhere.
- Arithmetic shift preserves sign, so a negative potential leaks toward zero from below.
- Boundary behaviour:
  - `in_valid` outside ACCUM is not accepted; the upstream source holds its beat.
  - `start` outside IDLE is ignored.
  - A single-beat timestep (first beat carries `in_last`) is legal.
  - `spike` outside FIRE is ignored.
  - `threshold` and `leak_shift` are sampled only in FIRE; they may change between timesteps.
- Reset at any time, including mid-timestep or in FIRE, returns to IDLE immediately.

## Timing
- Reset values: `in_ready`=0, `mp_valid`=0, `done`=0, `membrane_potential`=0, `timestep`=0; internal `vmem`=0, `acc`=0.
- `in_ready` and `mp_valid` decode combinationally from the state register.
- Last beat accepted at edge N → FIRE (with `mp_valid`) in cycle N+1 → `in_ready` high again in cycle N+2.
- Minimum timestep length is therefore 2 cycles; input throughput is 1 beat/cycle within a timestep.
- `start` accepted at edge S → `in_ready` high in cycle S+1.
- `done` goes high the cycle after the final FIRE, concurrently with IDLE. A `start` in that same cycle is honoured.

## Structure
- Shared package `snn_pkg`:
  - State enum (IDLE, ACCUM, FIRE).
  - `sat_add`/`sat_sub` functions parameterised on DATA_WIDTH.
  - Constants `DATA_MAX` and `DATA_MIN`.
- One natural sub-module: `saturating_adder` (signed a±b with clamp). Instantiate it for the `acc` path and the `vmem` path. The FIRE update may reuse it with the subtract select.
- Top level holds the FSM, the timestep counter, and the `vmem`/`acc`/`membrane_potential` registers.

## Test plan
- Reset, then `start`; beats 100, 200, 50(last) with `threshold`=300, `spike` modelled as `mp`≥`threshold`:
  - FIRE shows `membrane_potential`=350 and spike=1.
  - Next timestep, one beat 0(last) shows `membrane_potential`=50.
- `leak_shift`=1, no spike, single beat 64(last) for two timesteps: FIRE values 64, then 96 (32+64).
- Saturation: beats 0x7FFF and 0x0010 → `membrane_potential`=0x7FFF. Beats −32768 and −1 → −32768.
- NUM_TIMESTEPS=2, one-beat timesteps:
  - `done` pulses exactly once, one cycle after the second FIRE.
  - A back-to-back `start` in the `done` cycle restarts the frame with `vmem`=0.
- `in_valid` held high across FIRE and IDLE: no extra accepts; the beat count equals handshakes observed.
- Assert `rst` during ACCUM after 2 beats: all outputs return to reset values next cycle, and a later frame starts from potential 0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and saturating arithmetic helpers for the spiking-network datapath.
// Saturation bounds are set by a width argument so one helper serves every datapath width.
package snn_pkg;

  localparam int unsigned SNN_DATA_WIDTH = 16;

  localparam logic signed [SNN_DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(SNN_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SNN_DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(SNN_DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StFire
  } state_e;

  // Operands are sign-extended to 32 bits; the result is clamped to a width-bit signed range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned width);
    logic signed [33:0] s;
    logic signed [33:0] hi;
    logic signed [33:0] lo;
    s  = 34'(a) + 34'(b);
    hi = (34'sd1 <<< (width - 1)) - 34'sd1;
    lo = -(34'sd1 <<< (width - 1));
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return 32'(s);
  endfunction

  function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned width);
    logic signed [33:0] s;
    logic signed [33:0] hi;
    logic signed [33:0] lo;
    s  = 34'(a) - 34'(b);
    hi = (34'sd1 <<< (width - 1)) - 34'sd1;
    lo = -(34'sd1 <<< (width - 1));
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return 32'(s);
  endfunction

endpackage

// File: rtl/saturating_adder.sv
// Signed a +/- b that clamps to the representable range instead of wrapping.
module saturating_adder #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  input  logic                         sub_i,
  output logic signed [DATA_WIDTH-1:0] y_o
);

  logic signed [DATA_WIDTH:0] a_ext;
  logic signed [DATA_WIDTH:0] b_ext;
  logic signed [DATA_WIDTH:0] sum;

  always_comb begin
    a_ext = {a_i[DATA_WIDTH-1], a_i};
    b_ext = {b_i[DATA_WIDTH-1], b_i};
    sum   = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);
    // One guard bit: overflow shows as disagreement between the two top bits.
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      y_o = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      y_o = sum[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/membrane_element.sv
// Integrate-and-fire membrane stage: accumulates a timestep of partial sums, presents the
// potential for one FIRE cycle, then soft-resets on spike or leaks toward zero otherwise.
module membrane_element
  import snn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned NUM_TIMESTEPS = 8,
  localparam int unsigned TsWidth      = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic signed [DATA_WIDTH-1:0] partial_sum,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  input  logic [3:0]                   leak_shift,
  input  logic                         spike,
  output logic signed [DATA_WIDTH-1:0] membrane_potential,
  output logic                         mp_valid,
  output logic [TsWidth-1:0]           timestep,
  output logic                         done
);

  state_e state_q, state_d;
  logic signed [DATA_WIDTH-1:0] vmem_q, vmem_d;
  logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] mp_q, mp_d;
  logic [TsWidth-1:0]           ts_q, ts_d;
  logic                         done_q, done_d;

  logic signed [DATA_WIDTH-1:0] acc_sum;
  logic signed [DATA_WIDTH-1:0] vm_a, vm_b, vm_sum;
  logic                         vm_sub;
  logic signed [DATA_WIDTH-1:0] leak;
  logic                         is_fire;

  assign is_fire = (state_q == StFire);

  saturating_adder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_acc_add (
    .a_i  (acc_q),
    .b_i  (partial_sum),
    .sub_i(1'b0),
    .y_o  (acc_sum)
  );

  // Shared between the ACCUM integrate (vmem + acc) and the FIRE soft reset (mp - threshold).
  assign vm_a   = is_fire ? mp_q : vmem_q;
  assign vm_b   = is_fire ? threshold : acc_sum;
  assign vm_sub = is_fire;

  saturating_adder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_vmem_add (
    .a_i  (vm_a),
    .b_i  (vm_b),
    .sub_i(vm_sub),
    .y_o  (vm_sum)
  );

  // Leak has the same sign as mp and no larger magnitude, so mp - leak cannot overflow.
  assign leak = mp_q >>> leak_shift;

  always_comb begin
    state_d = state_q;
    vmem_d  = vmem_q;
    acc_d   = acc_q;
    mp_d    = mp_q;
    ts_d    = ts_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          vmem_d  = '0;
          acc_d   = '0;
          ts_d    = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (in_valid) begin
          acc_d = acc_sum;
          if (in_last) begin
            mp_d    = vm_sum;
            state_d = StFire;
          end
        end
      end
      StFire: begin
        if (spike) begin
          vmem_d = vm_sum;
        end else if (leak_shift != 4'd0) begin
          vmem_d = mp_q - leak;
        end else begin
          vmem_d = mp_q;
        end
        acc_d = '0;
        if (ts_q == TsWidth'(NUM_TIMESTEPS - 1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          ts_d    = ts_q + TsWidth'(1);
          state_d = StAccum;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vmem_q  <= '0;
      acc_q   <= '0;
      mp_q    <= '0;
      ts_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vmem_q  <= vmem_d;
      acc_q   <= acc_d;
      mp_q    <= mp_d;
      ts_q    <= ts_d;
      done_q  <= done_d;
    end
  end

  assign in_ready           = (state_q == StAccum);
  assign mp_valid           = is_fire;
  assign membrane_potential = mp_q;
  assign timestep           = ts_q;
  assign done               = done_q;

endmodule

// File: tb/tb_membrane_element.sv
// Self-checking bench for membrane_element against an integer-arithmetic frame model.
module tb_membrane_element;

  localparam int DW  = 16;
  localparam int NT  = 2;
  localparam int TSW = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic signed [DW-1:0] partial_sum;
  logic signed [DW-1:0] threshold;
  logic [3:0]           leak_shift;
  logic                 spike;
  logic signed [DW-1:0] membrane_potential;
  logic                 mp_valid;
  logic [TSW-1:0]       timestep;
  logic                 done;

  int checks   = 0;
  int failures = 0;
  int spike_mode = 0;  // 0 never, 1 mp >= threshold, 2 always
  int m_vmem = 0;
  int m_ts   = 0;
  int beats[$];
  bit keep_valid = 1'b0;
  int hs_cnt = 0;
  int obs_mp;
  logic obs_spike;

  membrane_element #(
    .DATA_WIDTH   (DW),
    .NUM_TIMESTEPS(NT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_last           (in_last),
    .partial_sum       (partial_sum),
    .threshold         (threshold),
    .leak_shift        (leak_shift),
    .spike             (spike),
    .membrane_potential(membrane_potential),
    .mp_valid          (mp_valid),
    .timestep          (timestep),
    .done              (done)
  );

  always #5 clk = ~clk;

  assign spike = (spike_mode == 2) || ((spike_mode == 1) && (membrane_potential >= threshold));

  always @(posedge clk) begin
    if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic int clamp(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int rand16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Drives the beats queue as one timestep; entered and left just after a rising edge.
  task automatic run_timestep(input int thr, input int ls);
    int acc;
    int mp;
    int budget;
    bit sp;
    logic [TSW-1:0] ets;
    threshold  = DW'(thr);
    leak_shift = 4'(ls);
    acc = 0;
    for (int i = 0; i < beats.size(); i++) begin
      if (!keep_valid && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid    = 1'b1;
      partial_sum = DW'(beats[i]);
      in_last     = (i == beats.size() - 1);
      budget = 0;
      @(negedge clk);
      while (!in_ready && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      checks++;
      if (!in_ready) begin
        failures++;
        $display("FAIL beat_accept: in_ready=%b after %0d cycles, required 1", in_ready, budget);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      acc = clamp(acc + beats[i]);
    end
    in_last = 1'b0;
    if (keep_valid) partial_sum = DW'(rand16());
    else in_valid = 1'b0;

    mp  = clamp(m_vmem + acc);
    ets = TSW'(m_ts);
    @(negedge clk);
    obs_mp    = int'(membrane_potential);
    obs_spike = spike;
    checks++;
    if (mp_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fire_decode: mp_valid=%b in_ready=%b, required 1 0", mp_valid, in_ready);
    end
    checks++;
    if (membrane_potential !== DW'(mp)) begin
      failures++;
      $display("FAIL fire_mp: membrane_potential=%0d, required %0d", membrane_potential, mp);
    end
    checks++;
    if (timestep !== ets) begin
      failures++;
      $display("FAIL fire_timestep: timestep=%0d, required %0d", timestep, ets);
    end

    sp = (spike_mode == 2) || ((spike_mode == 1) && (mp >= thr));
    if (sp) m_vmem = clamp(mp - thr);
    else if (ls != 0) m_vmem = mp - (mp >>> ls);
    else m_vmem = mp;

    @(posedge clk);
    #1;
    if (m_ts == NT - 1) begin
      m_ts = 0;
      checks++;
      if (done !== 1'b1 || mp_valid !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL frame_done: done=%b mp_valid=%b in_ready=%b, required 1 0 0",
                 done, mp_valid, in_ready);
      end
    end else begin
      m_ts++;
      checks++;
      if (in_ready !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL next_accum: in_ready=%b done=%b, required 1 0", in_ready, done);
      end
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    m_vmem = 0;
    m_ts   = 0;
    checks++;
    if (in_ready !== 1'b1 || done !== 1'b0 || timestep !== '0) begin
      failures++;
      $display("FAIL start: in_ready=%b done=%b timestep=%0d, required 1 0 0",
               in_ready, done, timestep);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; partial_sum = '0;
    threshold = '0; leak_shift = '0; spike_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || mp_valid !== 1'b0 || done !== 1'b0 ||
        membrane_potential !== '0 || timestep !== '0) begin
      failures++;
      $display("FAIL reset: rdy=%b mpv=%b done=%b mp=%0d ts=%0d, required all 0",
               in_ready, mp_valid, done, membrane_potential, timestep);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    spike_mode = 1;
    start_frame();
    beats = '{100, 200, 50};
    run_timestep(300, 0);
    checks++;
    if (obs_mp !== 350 || obs_spike !== 1'b1) begin
      failures++;
      $display("FAIL basic_fire: mp=%0d spike=%b, required 350 1", obs_mp, obs_spike);
    end
    beats = '{0};
    run_timestep(300, 0);
    checks++;
    if (obs_mp !== 50) begin
      failures++;
      $display("FAIL basic_soft_reset: mp=%0d, required 50", obs_mp);
    end
  endtask

  task automatic test_leak();
    spike_mode = 0;
    start_frame();
    beats = '{64};
    run_timestep(1000, 1);
    beats = '{64};
    run_timestep(1000, 1);
    checks++;
    if (obs_mp !== 96) begin
      failures++;
      $display("FAIL leak: mp=%0d, required 96", obs_mp);
    end
  endtask

  task automatic test_saturation();
    spike_mode = 0;
    start_frame();
    beats = '{32767, 16};
    run_timestep(0, 0);
    checks++;
    if (obs_mp !== 32767) begin
      failures++;
      $display("FAIL sat_pos: mp=%0d, required 32767", obs_mp);
    end
    beats = '{-32768, -1};
    run_timestep(0, 0);
    start_frame();
    beats = '{-32768, -1};
    run_timestep(0, 0);
    checks++;
    if (obs_mp !== -32768) begin
      failures++;
      $display("FAIL sat_neg: mp=%0d, required -32768", obs_mp);
    end
    beats = '{5};
    run_timestep(0, 0);
  endtask

  task automatic test_back_to_back();
    spike_mode = 2;
    start_frame();
    beats = '{1000};
    run_timestep(10, 0);
    beats = '{7};
    run_timestep(10, 0);
    start_frame();  // issued in the done cycle
    beats = '{123};
    run_timestep(10, 0);
    checks++;
    if (obs_mp !== 123) begin
      failures++;
      $display("FAIL back_to_back: mp=%0d, required 123", obs_mp);
    end
    beats = '{0};
    run_timestep(10, 0);
  endtask

  task automatic test_hold_valid();
    int h0;
    spike_mode = 0;
    keep_valid = 1'b1;
    in_valid   = 1'b1;
    h0 = hs_cnt;
    start_frame();
    beats = '{1, 2, 3};
    run_timestep(0, 2);
    beats = '{4};
    run_timestep(0, 2);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hs_cnt - h0 !== 4 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_valid: handshakes=%0d in_ready=%b, required 4 0", hs_cnt - h0, in_ready);
    end
    keep_valid = 1'b0;
    in_valid   = 1'b0;
  endtask

  task automatic test_reset_mid();
    spike_mode = 0;
    start_frame();
    in_valid = 1'b1;
    in_last  = 1'b0;
    partial_sum = 16'sd900;
    @(posedge clk);
    #1;
    partial_sum = 16'sd800;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || mp_valid !== 1'b0 || done !== 1'b0 ||
        membrane_potential !== '0 || timestep !== '0) begin
      failures++;
      $display("FAIL reset_mid: rdy=%b mpv=%b done=%b mp=%0d ts=%0d, required all 0",
               in_ready, mp_valid, done, membrane_potential, timestep);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    start_frame();
    beats = '{77};
    run_timestep(0, 0);
    checks++;
    if (obs_mp !== 77) begin
      failures++;
      $display("FAIL reset_mid_restart: mp=%0d, required 77", obs_mp);
    end
    beats = '{0};
    run_timestep(0, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      spike_mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      start_frame();
      for (int t = 0; t < NT; t++) begin
        int n;
        n = int'($urandom_range(1, 4));
        beats.delete();
        for (int b = 0; b < n; b++) beats.push_back(rand16());
        run_timestep(rand16(), int'($urandom_range(0, 15)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_leak();
    test_saturation();
    test_back_to_back();
    test_hold_valid();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
